// File: rtl/softmax_driver_if.sv
// Host-side command/result stream bundle for softmax_driver.
//   cmd_*  : host -> driver command stream (valid/ready), op + one 64-bit word
//   res_*  : driver -> host result stream (valid/ready), one vector/row + last flag
// master = host/DMA side, slave = driver side.
interface softmax_driver_if #(
  parameter int W = 64
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_last;

  modport master (
    output cmd_valid, cmd_op, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_last
  );
endinterface

// File: rtl/softmax_driver.sv
// softmax_driver: command-side initiator for one softmax engine.
// Turns host commands into the engine's lut_wr / execute / fetch / mode / in
// timing and captures the engine's out bus into a single-entry result stream.
// Ports:
//   clk, reset    shared clock, synchronous active-high reset
//   bus (slave)   cmd_valid/ready/op/data in, res_valid/ready/data/last out
//   err_partial   one-cycle pulse when buffered block rows are dropped
//   busy          FSM not idle, or a result is pending
//   sm_in, sm_lut_wr, sm_execute, sm_fetch, sm_mode   registered engine controls
//   sm_out        engine output bus
// Ops: 0/1 LUT lsb/msb word, 2 mode-0 vector, 3 mode-1 row beat (8 per block).
module softmax_driver #(
  parameter int bw       = 8,
  parameter int col      = 8,
  parameter int LUT_GAP  = 10,
  parameter int RUN0_LEN = 9
)(
  input  logic                clk,
  input  logic                reset,
  softmax_driver_if.slave     bus,
  output logic                err_partial,
  output logic                busy,
  output logic [col*bw-1:0]   sm_in,
  output logic [1:0]          sm_lut_wr,
  output logic                sm_execute,
  output logic                sm_fetch,
  output logic                sm_mode,
  input  logic [col*bw-1:0]   sm_out
);
  localparam int W         = col * bw;
  localparam int RW        = (col > 1) ? $clog2(col) : 1;
  // Last R_EXEC cycle: rows land on T2..T(col+1), then the engine needs
  // a few more cycles before the first fetch.
  localparam int EXEC_LAST = col + 5;
  localparam int FETCH_LEN = 5;
  localparam int CMAX_A    = (LUT_GAP > RUN0_LEN) ? LUT_GAP : RUN0_LEN;
  localparam int CMAX      = (CMAX_A > EXEC_LAST + 1) ? CMAX_A : EXEC_LAST + 1;
  localparam int CW        = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, LUT_ISSUE, LUT_WAIT, V_RUN, R_EXEC, R_FETCH, R_HOLD
  } state_t;

  state_t              state, state_d;
  logic [CW-1:0]       cyc, cyc_d;      // phase counter, meaning depends on state
  logic [RW-1:0]       cnt, cnt_d;      // buffered row beats
  logic [RW-1:0]       row, row_d;      // row being fetched
  logic [W-1:0]        sm_in_d;
  logic [1:0]          lut_wr_d;
  logic                exec_d, fetch_d, mode_d;
  logic                res_vld, rv_d;
  logic [W-1:0]        res_dat, rd_d;
  logic                res_lst, rl_d;
  logic                buf_we;
  logic [col-1:0][W-1:0] rows;
  logic [RW-1:0]       ld_idx;
  logic                cmd_ready, acc, res_acc;

  assign cmd_ready   = (state == IDLE) & ~res_vld & ~reset;
  assign acc         = bus.cmd_valid & cmd_ready;
  assign res_acc     = res_vld & bus.res_ready;
  assign err_partial = acc & (bus.cmd_op != 2'd3) & (cnt != '0);
  assign busy        = (state != IDLE) | res_vld;
  assign ld_idx      = RW'(cyc - CW'(1));

  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = res_vld;
  assign bus.res_data  = res_dat;
  assign bus.res_last  = res_lst;

  always_comb begin
    state_d  = state;
    cyc_d    = cyc;
    cnt_d    = cnt;
    row_d    = row;
    sm_in_d  = sm_in;
    lut_wr_d = 2'b00;
    exec_d   = 1'b0;
    fetch_d  = 1'b0;
    mode_d   = sm_mode;
    rv_d     = res_vld & ~bus.res_ready;
    rd_d     = res_dat;
    rl_d     = res_lst;
    buf_we   = 1'b0;
    case (state)
      IDLE: if (acc) begin
        if (bus.cmd_op != 2'd3) cnt_d = '0;   // partial block dropped
        case (bus.cmd_op)
          2'd0, 2'd1: begin
            sm_in_d  = bus.cmd_data;
            lut_wr_d = (bus.cmd_op == 2'd0) ? 2'b01 : 2'b10;
            state_d  = LUT_ISSUE;
          end
          2'd2: begin
            sm_in_d = bus.cmd_data;
            mode_d  = 1'b0;
            exec_d  = 1'b1;
            cyc_d   = '0;
            state_d = V_RUN;
          end
          default: begin
            buf_we = 1'b1;
            if (cnt == RW'(col - 1)) begin
              cnt_d   = '0;
              mode_d  = 1'b1;
              exec_d  = 1'b1;
              cyc_d   = '0;
              state_d = R_EXEC;
            end else begin
              cnt_d = cnt + RW'(1);
            end
          end
        endcase
      end
      LUT_ISSUE: begin
        cyc_d   = '0;
        state_d = LUT_WAIT;
      end
      LUT_WAIT: begin
        cyc_d = cyc + CW'(1);
        if (cyc == CW'(LUT_GAP - 2)) state_d = IDLE;
      end
      V_RUN: begin
        exec_d = 1'b1;
        cyc_d  = cyc + CW'(1);
        if (cyc == CW'(RUN0_LEN - 1)) begin
          // result is visible on the first cycle execute is low
          exec_d  = 1'b0;
          rv_d    = 1'b1;
          rd_d    = sm_out;
          rl_d    = 1'b1;
          state_d = IDLE;
        end
      end
      R_EXEC: begin
        cyc_d = cyc + CW'(1);
        // row k is loaded at the end of T(k+1) so it is on sm_in during T(k+2)
        if (cyc >= CW'(1) && cyc <= CW'(col)) sm_in_d = rows[ld_idx];
        if (cyc == CW'(EXEC_LAST)) begin
          fetch_d = 1'b1;
          cyc_d   = '0;
          row_d   = '0;
          state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        fetch_d = 1'b1;
        cyc_d   = cyc + CW'(1);
        // capture so the row's result is presented on F4; the register is
        // always free here because a row only starts once it has drained
        if (cyc == CW'(FETCH_LEN - 2)) begin
          rv_d = 1'b1;
          rd_d = sm_out;
          rl_d = (row == RW'(col - 1));
        end
        if (cyc == CW'(FETCH_LEN - 1)) begin
          cyc_d = '0;
          if (row == RW'(col - 1)) begin
            fetch_d = 1'b0;
            state_d = IDLE;
          end else if (res_acc) begin
            row_d = row + RW'(1);         // back-to-back next row
          end else begin
            fetch_d = 1'b0;
            state_d = R_HOLD;
          end
        end
      end
      R_HOLD: begin
        if (res_acc) begin
          fetch_d = 1'b1;
          cyc_d   = '0;
          row_d   = row + RW'(1);
          state_d = R_FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cyc        <= '0;
      cnt        <= '0;
      row        <= '0;
      sm_in      <= '0;
      sm_lut_wr  <= '0;
      sm_execute <= 1'b0;
      sm_fetch   <= 1'b0;
      sm_mode    <= 1'b0;
      res_vld    <= 1'b0;
      res_dat    <= '0;
      res_lst    <= 1'b0;
    end else begin
      state      <= state_d;
      cyc        <= cyc_d;
      cnt        <= cnt_d;
      row        <= row_d;
      sm_in      <= sm_in_d;
      sm_lut_wr  <= lut_wr_d;
      sm_execute <= exec_d;
      sm_fetch   <= fetch_d;
      sm_mode    <= mode_d;
      res_vld    <= rv_d;
      res_dat    <= rd_d;
      res_lst    <= rl_d;
    end
  end

  // Row buffer holds data only; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (buf_we) rows[cnt] <= bus.cmd_data;
  end
endmodule

// File: tb/tb_softmax_driver.sv
module tb_softmax_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic        err_partial, busy;
  logic [63:0] sm_in, sm_out;
  logic [1:0]  sm_lut_wr;
  logic        sm_execute, sm_fetch, sm_mode;

  softmax_driver_if #(.W(64)) bus();

  softmax_driver #(.bw(8), .col(8), .LUT_GAP(10), .RUN0_LEN(9)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .err_partial(err_partial), .busy(busy),
    .sm_in(sm_in), .sm_lut_wr(sm_lut_wr), .sm_execute(sm_execute),
    .sm_fetch(sm_fetch), .sm_mode(sm_mode), .sm_out(sm_out)
  );

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0, err_cnt = 0;
  logic last_err;

  typedef struct packed { logic [63:0] d; logic l; } res_t;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    nchk++; nfail++;
    $display("FAIL %s timeout/unexpected", name);
  endtask

  function automatic logic [63:0] rowv(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {8{b}};
  endfunction

  function automatic logic [63:0] blkres(input int r);
    logic [7:0] b;
    b = 8'h80 + r[7:0];
    return {8{b}};
  endfunction

  // Engine model: mode 0 answers vec_res; mode 1 answers blkres(row), the
  // row advancing after every 5 fetch cycles, restarting on a block execute.
  logic [63:0] vec_res;
  int fc, frow;
  always @(posedge clk) begin
    if (reset || (sm_execute && sm_mode)) begin
      fc <= 0; frow <= 0;
    end else if (sm_fetch) begin
      if (fc == 4) begin fc <= 0; frow <= frow + 1; end
      else fc <= fc + 1;
    end
  end
  assign sm_out = sm_mode ? blkres(frow) : vec_res;

  // Compare process: result stream against the expected queue, result
  // stability under back-pressure, and whole fetch windows.
  logic        prev_hold = 1'b0;
  logic [63:0] hold_d;
  logic        hold_l;
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (prev_hold) begin
        chk("res_hold_valid", bus.res_valid, 1'b1);
        chk("res_hold_data", bus.res_data, hold_d);
        chk("res_hold_last", bus.res_last, hold_l);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) fail("res_unexpected");
        else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_data", bus.res_data, e.d);
          chk("res_last", bus.res_last, e.l);
        end
      end
      if (fc != 0) chk("fetch_mid_row", sm_fetch, 1'b1);
      if (err_partial) err_cnt++;
    end
    prev_hold = !reset && bus.res_valid && !bus.res_ready;
    hold_d    = bus.res_data;
    hold_l    = bus.res_last;
  end

  task automatic send(input logic [1:0] op, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) fail("cmd_ready_wait");
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = d;
    #1 last_err = err_partial;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic push_block();
    for (int k = 0; k < 8; k++) exp_q.push_back('{d: blkres(k), l: (k == 7)});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sm_in"}, sm_in, 0);
    chk({tag, "_lut_wr"}, sm_lut_wr, 0);
    chk({tag, "_execute"}, sm_execute, 0);
    chk({tag, "_fetch"}, sm_fetch, 0);
    chk({tag, "_mode"}, sm_mode, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
    chk({tag, "_res_last"}, bus.res_last, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_partial"}, err_partial, 0);
  endtask

  // Starts on E0 (first cycle after the vector is accepted).
  task automatic watch_vector(input logic [63:0] vin, input logic [63:0] vout);
    int t, nexe, tres;
    t = 0; nexe = 0; tres = -1;
    while (tres < 0 && t < 40) begin
      @(negedge clk);
      if (sm_execute) begin
        nexe++;
        chk("vec_mode", sm_mode, 1'b0);
        chk("vec_in", sm_in, vin);
      end
      if (bus.res_valid) begin
        tres = t;
        chk("vec_exec_low_at_res", sm_execute, 1'b0);
        chk("vec_res_lit", bus.res_data, vout);
        chk("vec_last_lit", bus.res_last, 1'b1);
      end
      t++;
    end
    chk("vec_exec_len", nexe, 9);
    chk("vec_res_cycle", tres, 9);
  endtask

  // Starts on T0 (first cycle after the 8th beat is accepted).
  task automatic watch_block(input bit do_stall);
    int t, nres, nfetch, stall, nlast;
    int rt[8];
    bit stalled;
    t = 0; nres = 0; nfetch = 0; stall = 0; nlast = 0; stalled = 0;
    while (nres < 8 && t < 400) begin
      @(negedge clk);
      if (t == 0) chk("blk_mode", sm_mode, 1'b1);
      if (t < 14) chk("blk_exec_pulse", sm_execute, t == 0);
      if (t >= 2 && t <= 9) chk("blk_row_in", sm_in, rowv(t - 2));
      if (t == 14) chk("blk_fetch_start", sm_fetch, 1'b1);
      if (sm_fetch) nfetch++;
      if (stall > 0) begin
        chk("stall_fetch_low", sm_fetch, 1'b0);
        chk("stall_valid", bus.res_valid, 1'b1);
        stall--;
        if (stall == 0) bus.res_ready = 1'b1;
      end else if (bus.res_valid && do_stall && !stalled && nres == 2) begin
        bus.res_ready = 1'b0; stall = 20; stalled = 1'b1;
      end
      if (bus.res_valid && bus.res_ready) begin
        rt[nres] = t;
        if (bus.res_last) nlast++;
        nres++;
      end
      t++;
    end
    chk("blk_results", nres, 8);
    chk("blk_fetch_cycles", nfetch, 40);
    chk("blk_last_count", nlast, 1);
    if (!do_stall) begin
      chk("blk_first_res", rt[0], 18);
      for (int k = 1; k < 8; k++) chk("blk_res_spacing", rt[k] - rt[k-1], 5);
    end
  endtask

  int n, nwr, nrv, e0, sawx, nacc;

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_data = '0; bus.res_ready = 1'b1;
    vec_res = '0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready, 1'b1);

    // LUT words
    send(2'd0, 64'h0102030405060708);
    @(negedge clk);
    chk("lut_wr_lsb", sm_lut_wr, 2'b01);
    chk("lut_in", sm_in, 64'h0102030405060708);
    chk("lut_ready_low", bus.cmd_ready, 1'b0);
    n = 0; nwr = 0; nrv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
      if (sm_lut_wr != 2'b00) nwr++;
      if (bus.res_valid) nrv++;
    end
    chk("lut_gap", n, 9);
    chk("lut_wr_once", nwr, 0);
    chk("lut_no_res", nrv, 0);
    send(2'd1, 64'h1112131415161718);
    @(negedge clk);
    chk("lut_wr_msb", sm_lut_wr, 2'b10);
    chk("lut_in_msb", sm_in, 64'h1112131415161718);

    // mode-0 vector
    vec_res = 64'h2020202020202020;
    exp_q.push_back('{d: 64'h2020202020202020, l: 1'b1});
    send(2'd2, 64'h1010101010101010);
    watch_vector(64'h1010101010101010, 64'h2020202020202020);

    // full block, no back-pressure
    push_block();
    for (int k = 0; k < 8; k++) send(2'd3, rowv(k));
    watch_block(1'b0);

    // block with a 20-cycle stall on row 2
    push_block();
    for (int k = 0; k < 8; k++) send(2'd3, rowv(k));
    watch_block(1'b1);

    // partial block discarded by a vector
    e0 = err_cnt;
    for (int k = 0; k < 3; k++) send(2'd3, 64'hFFFFFFFFFFFFFFFF);
    vec_res = 64'h4444444444444444;
    exp_q.push_back('{d: 64'h4444444444444444, l: 1'b1});
    send(2'd2, 64'h3333333333333333);
    chk("err_partial_on_vec", last_err, 1'b1);
    watch_vector(64'h3333333333333333, 64'h4444444444444444);
    chk("err_partial_count", err_cnt - e0, 1);
    for (int k = 0; k < 7; k++) send(2'd3, rowv(k));
    sawx = 0;
    repeat (15) begin
      @(negedge clk);
      if (sm_execute || busy) sawx++;
    end
    chk("seven_beats_no_exec", sawx, 0);
    push_block();
    send(2'd3, rowv(7));
    watch_block(1'b0);

    // reset while fetching row 4
    push_block();
    for (int k = 0; k < 8; k++) send(2'd3, rowv(k));
    nacc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (nacc == 4 && sm_fetch) break;
      if (bus.res_valid && bus.res_ready) nacc++;
    end
    chk("reached_row4", nacc, 4);
    chk("row4_fetching", sm_fetch, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_zero("midrst");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", bus.cmd_ready, 1'b1);
    chk("idle_after_midrst", busy, 1'b0);

    // engine usable again
    vec_res = 64'h5A5A5A5A5A5A5A5A;
    exp_q.push_back('{d: 64'h5A5A5A5A5A5A5A5A, l: 1'b1});
    send(2'd2, 64'hA5A5A5A5A5A5A5A5);
    watch_vector(64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
